avst_frame_sink: RTL

- Avalon-ST video sink: the receiving end of the pixel stream produced by the VGA master.
- Accepts 30-bit packed RGB beats framed by startofpacket/endofpacket and repacks each pixel to COLOR_WIDTH.
- Writes each pixel into the per-core GPU frame memories, using the same band/core addressing scheme the VGA master reads with.
- Used for frame capture, loopback and as the write path into the PPU memories.

---
 rtl/gpu_video_pkg.sv | 31 +++
 rtl/frame_addr_gen.sv | 72 +++++++
 rtl/avst_frame_sink.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/gpu_video_pkg.sv
// Shared video types and pixel packing used by both the VGA master read path
// and the Avalon-ST frame sink write path.
package gpu_video_pkg;

  localparam int R_UI = 29;
  localparam int R_LI = 20;
  localparam int G_UI = 19;
  localparam int G_LI = 10;
  localparam int B_UI = 9;
  localparam int B_LI = 0;

  typedef logic [29:0] rgb30_t;

  typedef enum logic [1:0] {ST_IDLE, ST_RECV, ST_FLUSH} sink_state_e;

  // Keeps the top width/3 bits of each 10-bit channel; B lands at the LSBs.
  function automatic logic [29:0] pack_color(input rgb30_t c, input int width);
    logic [29:0] r;
    int          w;
    int          lsb;
    r = '0;
    w = width / 3;
    for (int k = 0; k < 3; k++) begin
      lsb = (k == 0) ? B_LI : ((k == 1) ? G_LI : R_LI);
      for (int b = 0; b < 10; b++)
        if (b < w) r[k*w + b] = c[lsb + 10 - w + b];
    end
    return r;
  endfunction

endpackage

// File: rtl/frame_addr_gen.sv
// Pixel counter plus band address / core index, stepped without a divider.
// Holds the position of the next pixel; restart rebases to pixel 0 this cycle.
module frame_addr_gen
  import gpu_video_pkg::*;
#(
  parameter int TOTAL  = 480000,
  parameter int BAND   = 48000,
  parameter int ADDR_W = 32,
  parameter int SEL_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              advance_i,
  input  logic              restart_i,
  output logic [$clog2(TOTAL)-1:0] pc_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [SEL_W-1:0]  sel_o,
  output logic              band_end_o,
  output logic              frame_last_o
);
  localparam int PC_W = $clog2(TOTAL);

  logic [PC_W-1:0]   pc_q, pc_d, pc_b;
  logic [ADDR_W-1:0] addr_q, addr_d, addr_b;
  logic [SEL_W-1:0]  sel_q, sel_d, sel_b;
  logic              last_b, bend_b;

  assign pc_o         = pc_q;
  assign addr_o       = addr_q;
  assign sel_o        = sel_q;
  assign band_end_o   = (addr_q == ADDR_W'(BAND - 1));
  assign frame_last_o = (pc_q == PC_W'(TOTAL - 1));

  always_comb begin
    pc_b   = restart_i ? '0 : pc_q;
    addr_b = restart_i ? '0 : addr_q;
    sel_b  = restart_i ? '0 : sel_q;
    last_b = restart_i ? (TOTAL == 1) : frame_last_o;
    bend_b = restart_i ? (BAND == 1) : band_end_o;
    pc_d   = pc_b;
    addr_d = addr_b;
    sel_d  = sel_b;
    if (advance_i) begin
      if (last_b) begin
        pc_d   = '0;
        addr_d = '0;
        sel_d  = '0;
      end else begin
        pc_d = pc_b + 1'b1;
        if (bend_b) begin
          addr_d = '0;
          sel_d  = sel_b + 1'b1;
        end else begin
          addr_d = addr_b + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= '0;
      addr_q <= '0;
      sel_q  <= '0;
    end else begin
      pc_q   <= pc_d;
      addr_q <= addr_d;
      sel_q  <= sel_d;
    end
  end

endmodule

// File: rtl/avst_frame_sink.sv
// Avalon-ST video sink: frames 30-bit RGB beats into banded PPU memory writes.
// Optional AVST_SINK_STATS_EN adds saturating good/bad frame counters.
module avst_frame_sink
  import gpu_video_pkg::*;
#(
  parameter int VGA_WIDTH     = 800,
  parameter int VGA_HEIGHT    = 600,
  parameter int CORES_COUNT   = 10,
  parameter int BUFFER_ADDR_W = 32,
  parameter int COLOR_WIDTH   = 16,
  localparam int SEL_W        = (CORES_COUNT > 1) ? $clog2(CORES_COUNT) : 1
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [29:0]              s_data,
  input  logic                     s_startofpacket,
  input  logic                     s_endofpacket,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic [COLOR_WIDTH-1:0]   wdata,
  output logic [BUFFER_ADDR_W-1:0] waddress,
  output logic [SEL_W-1:0]         wselect,
  output logic                     write,
  input  logic                     wready,
`ifdef AVST_SINK_STATS_EN
  output logic [15:0]              frames_ok,
  output logic [15:0]              frames_bad,
`endif
  output logic                     frame_done,
  output logic                     err_short,
  output logic                     err_long
);
  localparam int VGA_SIZE  = VGA_WIDTH * VGA_HEIGHT;
  localparam int BAND_SIZE = VGA_WIDTH * VGA_HEIGHT / CORES_COUNT;

  sink_state_e               state_q;
  logic                      write_q, done_q, short_q, long_q;
  logic [COLOR_WIDTH-1:0]    wdata_q;
  logic [BUFFER_ADDR_W-1:0]  waddr_q, ag_addr;
  logic [SEL_W-1:0]          wsel_q, ag_sel;
  logic [$clog2(VGA_SIZE)-1:0] ag_pc;
  logic                      ag_bend, ag_last;
  logic                      accept, sop, eop, pix_take;
  logic [29:0]               pix_full;
  logic                      unused_ok;

  // Ready depends only on the output register, never on s_valid.
  assign s_ready  = !write_q || wready;
  assign accept   = s_valid && s_ready;
  assign sop      = accept && s_startofpacket;
  assign eop      = s_endofpacket;
  assign pix_take = sop || (accept && state_q == ST_RECV);
  assign pix_full = pack_color(s_data, COLOR_WIDTH);
  assign unused_ok = &{1'b0, ag_bend, ag_pc, pix_full};

  frame_addr_gen #(
    .TOTAL (VGA_SIZE),
    .BAND  (BAND_SIZE),
    .ADDR_W(BUFFER_ADDR_W),
    .SEL_W (SEL_W)
  ) u_addr (
    .clk         (clk),
    .rst_n       (resetn),
    .advance_i   (pix_take),
    .restart_i   (sop),
    .pc_o        (ag_pc),
    .addr_o      (ag_addr),
    .sel_o       (ag_sel),
    .band_end_o  (ag_bend),
    .frame_last_o(ag_last)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      write_q <= 1'b0;
      wdata_q <= '0;
      waddr_q <= '0;
      wsel_q  <= '0;
      done_q  <= 1'b0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      if (write_q && wready) write_q <= 1'b0;
      if (pix_take) begin
        write_q <= 1'b1;
        wdata_q <= pix_full[COLOR_WIDTH-1:0];
        waddr_q <= sop ? '0 : ag_addr;
        wsel_q  <= sop ? '0 : ag_sel;
      end
      if (accept) begin
        // An SOP always restarts; it is an error only if it cuts a frame short.
        if (s_startofpacket) begin
          if (eop || state_q == ST_RECV) short_q <= 1'b1;
          state_q <= eop ? ST_IDLE : ST_RECV;
        end else begin
          case (state_q)
            ST_RECV: begin
              if (ag_last) begin
                if (eop) begin
                  done_q  <= 1'b1;
                  state_q <= ST_IDLE;
                end else begin
                  long_q  <= 1'b1;
                  state_q <= ST_FLUSH;
                end
              end else if (eop) begin
                short_q <= 1'b1;
                state_q <= ST_IDLE;
              end
            end
            ST_FLUSH: if (eop) state_q <= ST_IDLE;
            default:  state_q <= ST_IDLE;
          endcase
        end
      end
    end
  end

  assign write      = write_q;
  assign wdata      = wdata_q;
  assign waddress   = waddr_q;
  assign wselect    = wsel_q;
  assign frame_done = done_q;
  assign err_short  = short_q;
  assign err_long   = long_q;

`ifdef AVST_SINK_STATS_EN
  logic [15:0] ok_q, bad_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ok_q  <= '0;
      bad_q <= '0;
    end else begin
      if (done_q && ok_q != 16'hFFFF) ok_q <= ok_q + 16'd1;
      if ((short_q || long_q) && bad_q != 16'hFFFF) bad_q <= bad_q + 16'd1;
    end
  end

  assign frames_ok  = ok_q;
  assign frames_bad = bad_q;
`endif

endmodule
